result_checker: RTL
===================

Name: result_checker

Overview:
- Downstream consumer of the operand driver stage in the arithmetic testbench.
- Takes the delayed operand pair, aligned to DUT output timing, together with the DUT result.
- Computes the golden result, compares it with the DUT result, and keeps pass/fail statistics.
- Captures the first failing vector and reports run completion to the top-level test controller.

Parameters:
- WIDTH, 32: operand/result width. Only 32 is supported.
- NUM_TESTS, 1000: number of checked samples per run (1 to 2^32-1).
- STOP_ON_FAIL, 1: 1 = end the run at the first mismatch; 0 = continue to NUM_TESTS.

Ports:
- clk  in  1  testbench clock.
- reset  in  1  asynchronous, active-low reset.
- i_start  in  1  single-cycle pulse that begins a run.
- i_op  in  2  golden op select: 0 add, 1 sub (a-b), 2 mul (low 32 bits), 3 xor.
- i_valid  in  1  delayed operands and DUT result are valid this cycle.
- i_drive_delayed_a  in  32  operand A, aligned to the result.
- i_drive_delayed_b  in  32  operand B, aligned to the result.
- i_dut_result  in  32  DUT output.
- o_busy  out  1  run in progress.
- o_done  out  1  run finished; held until next start or reset.
- o_error  out  1  at least one mismatch this run; sticky.
- o_pass_count  out  32  matching samples this run.
- o_fail_count  out  32  mismatching samples this run.
- o_fail_a  out  32  A of the first failing sample.
- o_fail_b  out  32  B of the first failing sample.
- o_fail_result  out  32  DUT result of the first failing sample.
- o_fail_expected  out  32  golden result of the first failing sample.

Behaviour:
- Reset (reset=0, asynchronous): FSM to IDLE; all outputs 0. Reset takes effect mid-run, discarding the run.
- FSM states: IDLE, RUN, DONE.
  - IDLE: i_start -> RUN. On entry to RUN, counts, o_error, fail captures and o_done clear to 0; o_busy=1.
  - RUN: samples are checked only when i_valid=1. i_start is ignored.
  - RUN -> DONE when checked count (pass+fail) reaches NUM_TESTS, or on the first mismatch if STOP_ON_FAIL=1. Either transition happens on the edge that records the terminating sample.
  - DONE: o_busy=0, o_done=1. i_start -> RUN, with the same clearing as from IDLE.
- i_valid outside RUN is ignored; no counts change.
- i_op is sampled once on the i_start edge and held in a register for the whole run. Later changes to i_op have no effect.
- Golden compute is combinational from the current inputs, with modulo 2^32 arithmetic:
  - add wraps; sub wraps (0-1 = 0xFFFFFFFF).
  - mul keeps the low 32 bits of the 64-bit product.
- Check latency: 1 cycle. With i_valid=1 at edge n, the counts and captures are visible after edge n.
- Match: o_pass_count += 1.
- Mismatch: o_fail_count += 1; o_error <= 1.
  - If this is the first fail of the run, capture a, b, result and expected into o_fail_*.
  - Later fails leave the captures unchanged.
- Counts never exceed NUM_TESTS. No samples are accepted after the terminating sample.
- NUM_TESTS=1: the run ends on the first valid sample.

Test Plan:
1. Reset low mid-run (after 3 of 10 samples) -> all outputs 0 immediately (asynchronous); FSM in IDLE. After release, i_valid pulses produce no count change until i_start.
2. NUM_TESTS=4, op=add, operands (1,2),(0xFFFFFFFF,1),(5,5),(0x80000000,0x80000000), DUT returns 3,0,10,0 -> pass=4, fail=0, o_error=0, o_done=1 one cycle after the 4th valid.
3. STOP_ON_FAIL=1, op=sub, sample 2 is a=0,b=1 with DUT 0x00000000 -> fail=1, pass=1, fail_a=0, fail_b=1, fail_result=0, fail_expected=0xFFFFFFFF, o_done=1. A 3rd valid sample is ignored.
4. STOP_ON_FAIL=0, NUM_TESTS=5, op=mul, samples 2 and 4 wrong -> pass=3, fail=2. Captures hold sample 2. Check 0x10000*0x10000 expected 0.
5. i_start pulsed during RUN, and i_op changed mid-run -> no restart, no counter clear, golden op unchanged. i_start in DONE -> counts clear and a new run begins.
6. i_valid gaps (valid every 3rd cycle, NUM_TESTS=3, op=xor, a=0xA5A5A5A5, b=0xFFFFFFFF, DUT 0x5A5A5A5A) -> pass=3 only after the 3rd valid; o_busy stays 1 throughout the gaps.

Source files
------------

// File: rtl/result_checker.sv
// Scoreboard stage: recomputes the golden result for each valid operand pair, compares it with
// the DUT result, keeps pass/fail counts and latches the first failing vector of a run.
module result_checker #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned NUM_TESTS    = 1000,
  parameter bit          STOP_ON_FAIL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_drive_delayed_a,
  input  logic [WIDTH-1:0] i_drive_delayed_b,
  input  logic [WIDTH-1:0] i_dut_result,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [31:0]      o_pass_count,
  output logic [31:0]      o_fail_count,
  output logic [WIDTH-1:0] o_fail_a,
  output logic [WIDTH-1:0] o_fail_b,
  output logic [WIDTH-1:0] o_fail_result,
  output logic [WIDTH-1:0] o_fail_expected
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [31:0]      pass_q, pass_d;
  logic [31:0]      fail_q, fail_d;
  logic [WIDTH-1:0] fail_a_q, fail_a_d;
  logic [WIDTH-1:0] fail_b_q, fail_b_d;
  logic [WIDTH-1:0] fail_res_q, fail_res_d;
  logic [WIDTH-1:0] fail_exp_q, fail_exp_d;

  logic [WIDTH-1:0] expected;
  logic             mismatch;
  logic [31:0]      checked_nxt;
  logic             last_sample;

  // Golden model uses the op latched at start; mul keeps the low WIDTH bits of the product.
  always_comb begin
    expected = '0;
    unique case (op_q)
      2'd0: expected = i_drive_delayed_a + i_drive_delayed_b;
      2'd1: expected = i_drive_delayed_a - i_drive_delayed_b;
      2'd2: expected = i_drive_delayed_a * i_drive_delayed_b;
      2'd3: expected = i_drive_delayed_a ^ i_drive_delayed_b;
      default: expected = '0;
    endcase
  end

  assign mismatch    = (i_dut_result != expected);
  assign checked_nxt = pass_q + fail_q + 32'd1;
  assign last_sample = (checked_nxt == NUM_TESTS) || (mismatch && STOP_ON_FAIL);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    fail_a_d   = fail_a_q;
    fail_b_d   = fail_b_q;
    fail_res_d = fail_res_q;
    fail_exp_d = fail_exp_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (i_start) begin
          state_d    = StRun;
          op_d       = i_op;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          pass_d     = '0;
          fail_d     = '0;
          fail_a_d   = '0;
          fail_b_d   = '0;
          fail_res_d = '0;
          fail_exp_d = '0;
        end
      end
      StRun: begin
        if (i_valid) begin
          if (mismatch) begin
            fail_d  = fail_q + 32'd1;
            error_d = 1'b1;
            // Only the first failure of a run is captured.
            if (fail_q == '0) begin
              fail_a_d   = i_drive_delayed_a;
              fail_b_d   = i_drive_delayed_b;
              fail_res_d = i_dut_result;
              fail_exp_d = expected;
            end
          end else begin
            pass_d = pass_q + 32'd1;
          end
          if (last_sample) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      op_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      pass_q     <= '0;
      fail_q     <= '0;
      fail_a_q   <= '0;
      fail_b_q   <= '0;
      fail_res_q <= '0;
      fail_exp_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      fail_a_q   <= fail_a_d;
      fail_b_q   <= fail_b_d;
      fail_res_q <= fail_res_d;
      fail_exp_q <= fail_exp_d;
    end
  end

  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_error         = error_q;
  assign o_pass_count    = pass_q;
  assign o_fail_count    = fail_q;
  assign o_fail_a        = fail_a_q;
  assign o_fail_b        = fail_b_q;
  assign o_fail_result   = fail_res_q;
  assign o_fail_expected = fail_exp_q;

endmodule
